// File: rtl/wb_trap_ctrl.sv
// wb_trap_ctrl: registered write-back stage with a machine-mode trap controller.
//
// Selects the register-file write data for the instruction at this stage,
// commits it (and any CSR write) one cycle later, priority-encodes the
// exception request lines, owns the M-mode trap CSRs and sequences trap
// entry / MRET followed by a fixed-length pipeline drain.
//
// Optional feature macro: WB_IRQ_EN (adds irq_timer_i/irq_ext_i and the
// mie/mip CSRs; interrupts outrank every exception).
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   valid_i             instruction present at this stage
//   pc_i, instruction_i PC and raw word of that instruction
//   alu_d_i, mem_d_i    ALU result, aligned/extended load data
//   mem_addr_i          effective load/store address (mtval source)
//   csr_wd_i            CSR operand (rs1 value or zero-extended zimm)
//   exc_i[NEXC]         exception requests, bit 0 highest priority
//   rd_o, rf_wd_o, we_rf_o  registered register-file write port
//   trap_o, trap_pc_o   one-cycle fetch redirect and its target
//   flush_o, stall_o    high for DRAIN_CYCLES cycles after a redirect
//
// FSM states:
//   state   | meaning
//   S_RUN   | accepting instructions, may take a trap or MRET
//   S_DRAIN | flushing younger instructions, input ignored
module wb_trap_ctrl #(
  parameter int                NEXC            = 4,
  parameter logic [4*NEXC-1:0] EXC_CAUSES      = {4'd6, 4'd4, 4'd0, 4'd2},
  parameter logic [NEXC-1:0]   MTVAL_ADDR_MASK = 4'b1100,
  parameter logic [31:0]       MTVEC_RESET     = 32'h0000_0100,
  parameter int                DRAIN_CYCLES    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [31:0]     pc_i,
  input  logic [31:0]     instruction_i,
  input  logic [31:0]     alu_d_i,
  input  logic [31:0]     mem_d_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [31:0]     csr_wd_i,
  input  logic [NEXC-1:0] exc_i,
`ifdef WB_IRQ_EN
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
`endif
  output logic [4:0]      rd_o,
  output logic [31:0]     rf_wd_o,
  output logic            we_rf_o,
  output logic            trap_o,
  output logic [31:0]     trap_pc_o,
  output logic            flush_o,
  output logic            stall_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET_INSN = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
`ifdef WB_IRQ_EN
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MIP      = 12'h344;
`endif

  localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mst_mie_q, mst_mie_d;
  logic             mst_mpie_q, mst_mpie_d;
  logic [31:0]      mtvec_q, mtvec_d;
  logic [31:0]      mscratch_q, mscratch_d;
  logic [31:0]      mepc_q, mepc_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [31:0]      mtval_q, mtval_d;
`ifdef WB_IRQ_EN
  logic             mtie_q, mtie_d;
  logic             meie_q, meie_d;
`endif
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      rf_wd_q, rf_wd_d;
  logic             we_rf_q, we_rf_d;
  logic             trap_q, trap_d;
  logic [31:0]      trap_pc_q, trap_pc_d;
  logic             flush_q, flush_d;
  logic             stall_q, stall_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f;
  logic [11:0] csr_addr;

  assign opcode   = instruction_i[6:0];
  assign rd_f     = instruction_i[11:7];
  assign funct3   = instruction_i[14:12];
  assign rs1_f    = instruction_i[19:15];
  assign csr_addr = instruction_i[31:20];

  // CSR read view
  logic [31:0] csr_rdata;
  logic        csr_known;

  always_comb begin
    csr_rdata = 32'h0;
    csr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {24'h0, mst_mpie_q, 3'b000, mst_mie_q, 3'b000};
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
`ifdef WB_IRQ_EN
      CSR_MIE:      csr_rdata = {20'h0, meie_q, 3'b000, mtie_q, 7'h00};
      CSR_MIP:      csr_rdata = {20'h0, irq_ext_i, 3'b000, irq_timer_i, 7'h00};
`endif
      default:      csr_known = 1'b0;
    endcase
  end

  logic        csr_op, csr_illegal, csr_we_req;
  logic [31:0] csr_wdata;

  assign csr_op      = (opcode == OPC_SYSTEM) && (funct3 != 3'b000);
  assign csr_illegal = csr_op && ((funct3 == 3'b100) || !csr_known);
  // Set/clear forms with a zero rs1/zimm field are pure reads.
  assign csr_we_req  = csr_op && !csr_illegal && ((funct3[1:0] == 2'b01) || (rs1_f != 5'd0));

  always_comb begin
    case (funct3[1:0])
      2'b01:   csr_wdata = csr_wd_i;
      2'b10:   csr_wdata = csr_rdata | csr_wd_i;
      2'b11:   csr_wdata = csr_rdata & ~csr_wd_i;
      default: csr_wdata = csr_rdata;
    endcase
  end

  // Exception priority: scan from the top so the lowest active index wins.
  logic       exc_hit, exc_addr;
  logic [3:0] exc_cause;

  always_comb begin
    exc_hit   = 1'b0;
    exc_addr  = 1'b0;
    exc_cause = 4'd0;
    for (int i = NEXC - 1; i >= 0; i--) begin
      if (exc_i[i]) begin
        exc_hit   = 1'b1;
        exc_cause = EXC_CAUSES[4*i +: 4];
        exc_addr  = MTVAL_ADDR_MASK[i];
      end
    end
  end

  logic irq_ext_take, irq_tmr_take;
`ifdef WB_IRQ_EN
  assign irq_ext_take = mst_mie_q && meie_q && irq_ext_i;
  assign irq_tmr_take = mst_mie_q && mtie_q && irq_timer_i;
`else
  assign irq_ext_take = 1'b0;
  assign irq_tmr_take = 1'b0;
`endif

  logic [31:0] trap_cause, trap_val;

  always_comb begin
    if (irq_ext_take) begin
      trap_cause = 32'h8000_000B;
      trap_val   = 32'h0;
    end else if (irq_tmr_take) begin
      trap_cause = 32'h8000_0007;
      trap_val   = 32'h0;
    end else if (exc_hit) begin
      trap_cause = {28'h0, exc_cause};
      trap_val   = exc_addr ? mem_addr_i : instruction_i;
    end else begin
      trap_cause = 32'd2;
      trap_val   = instruction_i;
    end
  end

  logic active, take_trap, take_mret, retire;

  assign active    = valid_i && (state_q == S_RUN);
  assign take_trap = active && (irq_ext_take || irq_tmr_take || exc_hit || csr_illegal);
  assign take_mret = active && !take_trap && (instruction_i == MRET_INSN);
  assign retire    = active && !take_trap;

  // Write-back data select
  logic        rf_writes;
  logic [31:0] rf_data;

  always_comb begin
    rf_writes = 1'b1;
    rf_data   = 32'h0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: rf_data = alu_d_i;
      OPC_LOAD:                               rf_data = mem_d_i;
      OPC_JAL, OPC_JALR:                      rf_data = pc_i + 32'd4;
      OPC_SYSTEM: begin
        rf_writes = csr_op;
        rf_data   = csr_rdata;
      end
      default:                                rf_writes = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
`ifdef WB_IRQ_EN
    mtie_d     = mtie_q;
    meie_d     = meie_q;
`endif
    rd_d       = rd_q;
    rf_wd_d    = rf_wd_q;
    we_rf_d    = 1'b0;
    trap_d     = 1'b0;
    trap_pc_d  = trap_pc_q;
    flush_d    = 1'b0;
    stall_d    = 1'b0;

    case (state_q)
      S_RUN: begin
        if (take_trap) begin
          mepc_d     = {pc_i[31:2], 2'b00};
          mcause_d   = trap_cause;
          mtval_d    = trap_val;
          mst_mpie_d = mst_mie_q;
          mst_mie_d  = 1'b0;
          trap_d     = 1'b1;
          trap_pc_d  = mtvec_q;
        end else if (take_mret) begin
          mst_mie_d  = mst_mpie_q;
          mst_mpie_d = 1'b1;
          trap_d     = 1'b1;
          trap_pc_d  = mepc_q;
        end else if (retire) begin
          if (rf_writes && (rd_f != 5'd0)) begin
            we_rf_d = 1'b1;
            rd_d    = rd_f;
            rf_wd_d = rf_data;
          end
          if (csr_we_req) begin
            case (csr_addr)
              CSR_MSTATUS: begin
                mst_mie_d  = csr_wdata[3];
                mst_mpie_d = csr_wdata[7];
              end
              CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 2'b00};
              CSR_MSCRATCH: mscratch_d = csr_wdata;
              CSR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
              CSR_MCAUSE:   mcause_d   = csr_wdata;
              CSR_MTVAL:    mtval_d    = csr_wdata;
`ifdef WB_IRQ_EN
              CSR_MIE: begin
                mtie_d = csr_wdata[7];
                meie_d = csr_wdata[11];
              end
`endif
              default: ;
            endcase
          end
        end
        if (take_trap || take_mret) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
`ifdef WB_IRQ_EN
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
`endif
      rd_q       <= 5'd0;
      rf_wd_q    <= 32'h0;
      we_rf_q    <= 1'b0;
      trap_q     <= 1'b0;
      trap_pc_q  <= 32'h0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
`ifdef WB_IRQ_EN
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
`endif
      rd_q       <= rd_d;
      rf_wd_q    <= rf_wd_d;
      we_rf_q    <= we_rf_d;
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
      flush_q    <= flush_d;
      stall_q    <= stall_d;
    end
  end

  assign rd_o      = rd_q;
  assign rf_wd_o   = rf_wd_q;
  assign we_rf_o   = we_rf_q;
  assign trap_o    = trap_q;
  assign trap_pc_o = trap_pc_q;
  assign flush_o   = flush_q;
  assign stall_o   = stall_q;

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Testbench for wb_trap_ctrl (default build, interrupts disabled).
module tb_wb_trap_ctrl;

  localparam int DRAIN = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, mem_d_i, mem_addr_i, csr_wd_i;
  logic [3:0]  exc_i;
  logic [4:0]  rd_o;
  logic [31:0] rf_wd_o, trap_pc_o;
  logic        we_rf_o, trap_o, flush_o, stall_o;

  wb_trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .alu_d_i(alu_d_i), .mem_d_i(mem_d_i),
    .mem_addr_i(mem_addr_i), .csr_wd_i(csr_wd_i), .exc_i(exc_i),
    .rd_o(rd_o), .rf_wd_o(rf_wd_o), .we_rf_o(we_rf_o), .trap_o(trap_o),
    .trap_pc_o(trap_pc_o), .flush_o(flush_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  int          m_drain;
  logic        e_we, e_trap, e_flush;
  logic [4:0]  e_rd;
  logic [31:0] e_wd, e_tpc;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] line_cause(input int i);
    case (i)
      0:       return 32'd2;
      1:       return 32'd0;
      2:       return 32'd4;
      default: return 32'd6;
    endcase
  endfunction

  function automatic bit m_csr_known(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
  endfunction

  function automatic logic [31:0] m_csr_read(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
    m_drain = 0;
    e_we = 0; e_trap = 0; e_flush = 0; e_rd = 0; e_wd = 0; e_tpc = 0;
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1;
    logic [11:0] ca;
    logic [31:0] old, nv, wd;
    bit          is_csr, illegal, writes, do_w;
    int          line;
    e_trap = 0;
    e_we   = 0;
    if (m_drain > 0) begin
      m_drain--;
      e_flush = (m_drain > 0);
      return;
    end
    e_flush = 0;
    if (!valid_i) return;
    op  = instruction_i[6:0];
    rd  = instruction_i[11:7];
    f3  = instruction_i[14:12];
    rs1 = instruction_i[19:15];
    ca  = instruction_i[31:20];
    is_csr  = (op == 7'h73) && (f3 != 3'd0);
    illegal = is_csr && ((f3 == 3'd4) || !m_csr_known(ca));
    line = -1;
    for (int i = 3; i >= 0; i--) if (exc_i[i]) line = i;
    if (line >= 0 || illegal) begin
      m_mepc = pc_i & ~32'h3;
      if (line >= 0) begin
        m_mcause = line_cause(line);
        m_mtval  = (line >= 2) ? mem_addr_i : instruction_i;
      end else begin
        m_mcause = 32'd2;
        m_mtval  = instruction_i;
      end
      m_mpie = m_mie; m_mie = 0;
      e_trap = 1; e_tpc = m_mtvec; e_flush = 1; m_drain = DRAIN;
      return;
    end
    if (instruction_i == 32'h3020_0073) begin
      e_tpc = m_mepc;
      m_mie = m_mpie; m_mpie = 1;
      e_trap = 1; e_flush = 1; m_drain = DRAIN;
      return;
    end
    writes = 1;
    wd = 0;
    case (op)
      7'h33, 7'h13, 7'h37, 7'h17: wd = alu_d_i;
      7'h03:                      wd = mem_d_i;
      7'h6f, 7'h67:               wd = pc_i + 32'd4;
      7'h73:                      writes = is_csr;
      default:                    writes = 0;
    endcase
    if (is_csr) begin
      old  = m_csr_read(ca);
      wd   = old;
      nv   = old;
      do_w = 0;
      case (f3[1:0])
        2'b01: begin nv = csr_wd_i; do_w = 1; end
        2'b10: begin nv = old | csr_wd_i;  do_w = (rs1 != 0); end
        2'b11: begin nv = old & ~csr_wd_i; do_w = (rs1 != 0); end
        default: do_w = 0;
      endcase
      if (do_w) begin
        case (ca)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec    = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          default: ;
        endcase
      end
    end
    if (writes && rd != 0) begin
      e_we = 1; e_rd = rd; e_wd = wd;
    end
  endtask

  task automatic check_outputs();
    chk1("we_rf_o", we_rf_o, e_we);
    if (e_we) begin
      chk32("rd_o", {27'h0, rd_o}, {27'h0, e_rd});
      chk32("rf_wd_o", rf_wd_o, e_wd);
    end
    chk1("trap_o", trap_o, e_trap);
    if (e_trap) chk32("trap_pc_o", trap_pc_o, e_tpc);
    chk1("flush_o", flush_o, e_flush);
    chk1("stall_o", stall_o, e_flush);
  endtask

  task automatic step();
    model_step();
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] exc);
    valid_i = v; instruction_i = ins; exc_i = exc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 4'h0);
      step();
    end
  endtask

  function automatic logic [31:0] i_add(input logic [4:0] rd);
    return {7'h00, 5'd2, 5'd1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_csr(input logic [11:0] a, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {a, rs1, f3, rd, 7'h73};
  endfunction

  task automatic csr_read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(1'b1, i_csr(a, 5'd0, 3'b010, 5'd10), 4'h0);
    step();
    chk1({name, "_we"}, we_rf_o, 1'b1);
    chk32(name, rf_wd_o, exp);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [4:0]  rd, rs1;
    logic [11:0] ca;
    logic [2:0]  f3;
    rd  = 5'($urandom_range(0, 31));
    rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    case ($urandom_range(0, 9))
      0: return {7'h00, rs1, 5'd1, 3'b000, rd, 7'h33};
      1: return {12'h123, rs1, 3'b000, rd, 7'h13};
      2: return {12'h004, rs1, 3'b010, rd, 7'h03};
      3: return {20'h00010, rd, 7'h6f};
      4: return {12'h000, rs1, 3'b000, rd, 7'h67};
      5: return {7'h00, 5'd2, rs1, 3'b010, 5'd4, 7'h23};
      6, 7: begin
        case ($urandom_range(0, 7))
          0: ca = 12'h300; 1: ca = 12'h305; 2: ca = 12'h340; 3: ca = 12'h341;
          4: ca = 12'h342; 5: ca = 12'h343; 6: ca = 12'h7C0; default: ca = 12'h304;
        endcase
        f3 = 3'($urandom_range(1, 7));
        return {ca, rs1, f3, rd, 7'h73};
      end
      8: return 32'h3020_0073;
      default: return {20'hABCDE, rd, 7'h37};
    endcase
  endfunction

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
  } wb_vec_t;

  wb_vec_t vecs [10];

  initial begin
    vecs[0] = '{i_add(5'd5), 32'h40, 32'h1234, 32'h0, 1'b1, 5'd5, 32'h1234};
    vecs[1] = '{i_add(5'd0), 32'h40, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[2] = '{{20'h00010, 5'd1, 7'h6f}, 32'hFFFF_FFFC, 32'h9, 32'h0, 1'b1, 5'd1, 32'h0};
    vecs[3] = '{{12'h004, 5'd3, 3'b010, 5'd7, 7'h03}, 32'h50, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'hDEAD_BEEF};
    vecs[4] = '{{20'hABCDE, 5'd3, 7'h37}, 32'h54, 32'hABCD_E000, 32'h0, 1'b1, 5'd3, 32'hABCD_E000};
    vecs[5] = '{{20'h10000, 5'd9, 7'h17}, 32'h80, 32'h1000_0080, 32'h0, 1'b1, 5'd9, 32'h1000_0080};
    vecs[6] = '{{12'h000, 5'd1, 3'b000, 5'd31, 7'h67}, 32'h100, 32'h7, 32'h0, 1'b1, 5'd31, 32'h104};
    vecs[7] = '{{7'h00, 5'd2, 5'd1, 3'b010, 5'd4, 7'h23}, 32'h60, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0};
    vecs[8] = '{{7'h00, 5'd2, 5'd1, 3'b000, 5'd4, 7'h63}, 32'h64, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0};
    vecs[9] = '{{12'h055, 5'd1, 3'b000, 5'd12, 7'h13}, 32'h68, 32'h55, 32'h0, 1'b1, 5'd12, 32'h55};

    rst_i = 0;
    valid_i = 0; pc_i = 0; instruction_i = 0; alu_d_i = 0; mem_d_i = 0;
    mem_addr_i = 0; csr_wd_i = 0; exc_i = 0;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    chk1("rst_we", we_rf_o, 1'b0);
    chk1("rst_trap", trap_o, 1'b0);
    chk1("rst_flush", flush_o, 1'b0);
    chk32("rst_trap_pc", trap_pc_o, 32'h0);
    #2 rst_i = 1;

    csr_read_chk("rst_mtvec", 12'h305, 32'h100);
    csr_read_chk("rst_mstatus", 12'h300, 32'h0);
    csr_read_chk("rst_mepc", 12'h341, 32'h0);

    // Write-back select table
    for (int i = 0; i < 10; i++) begin
      pc_i = vecs[i].pc; alu_d_i = vecs[i].alu; mem_d_i = vecs[i].mem;
      drive(1'b1, vecs[i].insn, 4'h0);
      step();
      chk1($sformatf("vec%0d_we", i), we_rf_o, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk32($sformatf("vec%0d_rd", i), {27'h0, rd_o}, {27'h0, vecs[i].exp_rd});
        chk32($sformatf("vec%0d_wd", i), rf_wd_o, vecs[i].exp_wd);
      end
    end

    // Exception on line 2 (line 3 also active), drain ignores valid input
    pc_i = 32'h80; mem_addr_i = 32'h1003; alu_d_i = 32'h77;
    drive(1'b1, i_add(5'd5), 4'b1100);
    step();
    chk1("exc_trap", trap_o, 1'b1);
    chk32("exc_trap_pc", trap_pc_o, 32'h100);
    chk1("exc_flush0", flush_o, 1'b1);
    chk1("exc_we", we_rf_o, 1'b0);
    drive(1'b1, i_add(5'd6), 4'h0);
    step();
    chk1("exc_flush1", flush_o, 1'b1);
    chk1("exc_trap_once", trap_o, 1'b0);
    step();
    chk1("exc_flush2", flush_o, 1'b0);
    chk1("exc_drain_we", we_rf_o, 1'b0);
    step();
    chk1("exc_after_drain_we", we_rf_o, 1'b1);
    csr_read_chk("exc_mcause", 12'h342, 32'd4);
    csr_read_chk("exc_mtval", 12'h343, 32'h1003);
    csr_read_chk("exc_mepc", 12'h341, 32'h80);

    // mtvec write, zero-rs1 set, illegal CSR
    csr_wd_i = 32'h2003;
    drive(1'b1, i_csr(12'h305, 5'd1, 3'b001, 5'd6), 4'h0);
    step();
    chk32("csrrw_old_mtvec", rf_wd_o, 32'h100);
    csr_read_chk("mtvec_new", 12'h305, 32'h2000);
    csr_wd_i = 32'hFFFF_FFFF;
    drive(1'b1, i_csr(12'h340, 5'd0, 3'b010, 5'd7), 4'h0);
    step();
    csr_read_chk("mscratch_nowrite", 12'h340, 32'h0);
    drive(1'b1, i_csr(12'h7C0, 5'd0, 3'b010, 5'd8), 4'h0);
    step();
    chk1("ill_trap", trap_o, 1'b1);
    chk32("ill_trap_pc", trap_pc_o, 32'h2000);
    idle(DRAIN);
    csr_read_chk("ill_mcause", 12'h342, 32'd2);
    csr_read_chk("ill_mtval", 12'h343, i_csr(12'h7C0, 5'd0, 3'b010, 5'd8));

    // MIE/MPIE through trap and MRET
    csr_wd_i = 32'h8;
    drive(1'b1, i_csr(12'h300, 5'd8, 3'b110, 5'd0), 4'h0);
    step();
    csr_read_chk("mstatus_mie", 12'h300, 32'h08);
    pc_i = 32'h300;
    drive(1'b1, i_add(5'd3), 4'b0001);
    step();
    chk1("l0_trap", trap_o, 1'b1);
    idle(DRAIN);
    csr_read_chk("trap_mstatus", 12'h300, 32'h80);
    csr_read_chk("l0_mcause", 12'h342, 32'd2);
    csr_wd_i = 32'h447;
    drive(1'b1, i_csr(12'h341, 5'd1, 3'b001, 5'd0), 4'h0);
    step();
    drive(1'b1, 32'h3020_0073, 4'h0);
    step();
    chk1("mret_trap", trap_o, 1'b1);
    chk32("mret_pc", trap_pc_o, 32'h444);
    idle(DRAIN);
    csr_read_chk("mret_mstatus", 12'h300, 32'h88);

    // mtvec write visible to a trap in the very next cycle
    csr_wd_i = 32'h3000;
    drive(1'b1, i_csr(12'h305, 5'd1, 3'b001, 5'd0), 4'h0);
    step();
    drive(1'b1, i_add(5'd4), 4'b0010);
    step();
    chk32("mtvec_next_cycle", trap_pc_o, 32'h3000);
    idle(DRAIN);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      pc_i       = $urandom() & ~32'h3;
      alu_d_i    = $urandom();
      mem_d_i    = $urandom();
      mem_addr_i = $urandom();
      csr_wd_i   = $urandom();
      drive(($urandom_range(0, 4) != 0),
            rand_insn(),
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      step();
    end
    idle(DRAIN);

    // Asynchronous reset in the middle of a drain
    pc_i = 32'h40;
    drive(1'b1, i_add(5'd5), 4'b0100);
    step();
    chk1("pre_rst_flush", flush_o, 1'b1);
    #2 rst_i = 0;
    #1;
    chk1("arst_trap", trap_o, 1'b0);
    chk1("arst_flush", flush_o, 1'b0);
    chk1("arst_stall", stall_o, 1'b0);
    chk1("arst_we", we_rf_o, 1'b0);
    chk32("arst_trap_pc", trap_pc_o, 32'h0);
    chk32("arst_wd", rf_wd_o, 32'h0);
    drive(1'b0, 32'h0, 4'h0);
    @(posedge clk_i);
    #3 rst_i = 1;
    model_reset();
    csr_read_chk("post_rst_mtvec", 12'h305, 32'h100);
    alu_d_i = 32'h5A5A;
    drive(1'b1, i_add(5'd5), 4'h0);
    step();
    chk1("post_rst_run_we", we_rf_o, 1'b1);
    chk32("post_rst_run_wd", rf_wd_o, 32'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
